// File: rtl/fetch_queue.sv
// Instruction fetch unit: one-outstanding-request memory front end feeding a DEPTH-entry fall-through queue.
// Optional stall counter under FETCH_QUEUE_PERF_EN; requests stop while the queue is full, halted or in error.
module fetch_queue #(
  parameter int unsigned      WIDTH  = 16,
  parameter int unsigned      DEPTH  = 4,
  parameter logic [WIDTH-1:0] RST_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [WIDTH-1:0]         redirect_pc,
  input  logic                     halt,
  output logic [WIDTH-1:0]         imem_addr,
  output logic                     imem_rd,
  input  logic [WIDTH-1:0]         imem_data,
  input  logic                     imem_done,
  input  logic                     imem_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_instr,
  output logic [WIDTH-1:0]         out_pc_inc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err,
  output logic [15:0]              perf_stall_cnt
);

  localparam int unsigned      AW      = $clog2(DEPTH);
  localparam logic [AW:0]      DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(WIDTH / 8);

  typedef enum logic [1:0] {IDLE, REQ, DROP, HALTED} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc_inc;
  } entry_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             err_q;
  entry_t           q_mem [DEPTH];
  entry_t           head;

  logic issue_ok;
  logic push;
  logic pop;
  logic take_err;

  assign pc_plus  = pc + PC_STEP;
  // A pop in the same cycle does not free a slot for the issue decision.
  assign issue_ok = (state == IDLE) && !halt && !err_q && !redirect && (count_q < DEPTH_C);
  assign push     = (state == REQ) && imem_done && !imem_err && !redirect;
  assign take_err = (state == REQ) && imem_done && imem_err;
  assign pop      = (count_q != '0) && out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (issue_ok) begin
          state_nxt = REQ;
        end else if (redirect && halt) begin
          state_nxt = HALTED;
        end
      end
      REQ: begin
        if (imem_done) begin
          state_nxt = (imem_err || halt) ? HALTED : IDLE;
        end else if (redirect) begin
          state_nxt = DROP;
        end
      end
      // The abandoned request is still in flight; wait for its completion before issuing again.
      DROP: begin
        if (imem_done) begin
          state_nxt = IDLE;
        end
      end
      HALTED: begin
        if (!halt && !err_q) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= RST_PC;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take_err) begin
        err_q <= 1'b1;
      end
      if (redirect) begin
        pc      <= redirect_pc;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          pc     <= pc_plus;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wr_ptr] <= '{instr: imem_data, pc_inc: pc_plus};
    end
  end

  assign head       = q_mem[rd_ptr];
  assign out_valid  = (count_q != '0);
  assign out_instr  = head.instr;
  assign out_pc_inc = head.pc_inc;
  assign count      = count_q;
  assign err        = err_q;
  assign imem_addr  = pc;
  // Request is raised in the IDLE cycle that decides to issue, so memory sees it one cycle earlier.
  assign imem_rd    = !rst && ((state == REQ) || issue_ok);

`ifdef FETCH_QUEUE_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state == REQ) && !imem_done && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign perf_stall_cnt = stall_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        halt = 1'b0;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data = 16'h0;
  logic        imem_done = 1'b0;
  logic        imem_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr;
  logic [15:0] out_pc_inc;
  logic [2:0]  count;
  logic        err;
  logic [15:0] perf_stall_cnt;

  fetch_queue dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data), .imem_done(imem_done),
    .imem_err(imem_err), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc_inc(out_pc_inc), .count(count), .err(err), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

`ifdef FETCH_QUEUE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_inc;
  } ent_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // memory model
  bit          mem_busy = 1'b0;
  bit          was_busy = 1'b0;
  logic [15:0] mem_addr = 16'h0;
  int          mem_due = 0;
  int          mem_lat = 1;
  bit          err_inject = 1'b0;
  int          issues = 0;

  // reference model
  ent_t        mq[$];
  logic [15:0] m_pc = 16'h0;
  bit          m_err = 1'b0;
  bit          m_stale = 1'b0;
  int          m_stall = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Drive memory response for this cycle, check outputs, then update the model for the coming edge.
  task settle();
    logic [15:0] exp_perf;
    bit          allowed;
    was_busy  = mem_busy;
    imem_done = mem_busy && (cyc >= mem_due);
    imem_data = imem_done ? mem_word(mem_addr) : 16'h0;
    imem_err  = imem_done && err_inject;
    #1;
    if (rst) begin
      checks++;
      if (imem_rd !== 1'b0) begin
        errors++; $display("FAIL rd_in_reset: got %b expected 0", imem_rd);
      end
      mq.delete();
      m_pc    = 16'h0;
      m_err   = 1'b0;
      m_stall = 0;
      m_stale = mem_busy && !imem_done;
    end else begin
      exp_perf = PERF ? 16'(m_stall) : 16'h0;
      checks++;
      if (out_valid !== (mq.size() != 0)) begin
        errors++; $display("FAIL model_valid cyc %0d: got %b expected %b", cyc, out_valid, mq.size() != 0);
      end
      checks++;
      if (count !== 3'(mq.size())) begin
        errors++; $display("FAIL model_count cyc %0d: got %0d expected %0d", cyc, count, mq.size());
      end
      checks++;
      if (err !== m_err) begin
        errors++; $display("FAIL model_err cyc %0d: got %b expected %b", cyc, err, m_err);
      end
      checks++;
      if (perf_stall_cnt !== exp_perf) begin
        errors++; $display("FAIL model_perf cyc %0d: got %0d expected %0d", cyc, perf_stall_cnt, exp_perf);
      end
      if (mq.size() != 0) begin
        checks++;
        if (out_instr !== mq[0].instr || out_pc_inc !== mq[0].pc_inc) begin
          errors++; $display("FAIL model_head cyc %0d: got %h/%h expected %h/%h",
                             cyc, out_instr, out_pc_inc, mq[0].instr, mq[0].pc_inc);
        end
      end
      if (imem_rd === 1'b1 && !was_busy) begin
        allowed = !halt && !m_err && !redirect && (mq.size() < 4);
        checks++;
        if (!allowed || imem_addr !== m_pc) begin
          errors++; $display("FAIL model_issue cyc %0d: allowed %b addr %h expected %h", cyc, allowed, imem_addr, m_pc);
        end
      end
      if (imem_rd === 1'b1 && was_busy) begin
        checks++;
        if (m_stale || imem_addr !== mem_addr) begin
          errors++; $display("FAIL model_hold cyc %0d: stale %b addr %h expected %h", cyc, m_stale, imem_addr, mem_addr);
        end
      end
      if (m_err) begin
        checks++;
        if (imem_rd !== 1'b0) begin
          errors++; $display("FAIL model_rd_after_err cyc %0d: got %b expected 0", cyc, imem_rd);
        end
      end
      if (was_busy && !imem_done && !m_stale) m_stall++;
      if (mq.size() != 0 && out_ready && !redirect) void'(mq.pop_front());
      if (imem_done) begin
        if (m_stale) begin
          m_stale = 1'b0;
        end else if (imem_err) begin
          m_err = 1'b1;
        end else if (!redirect) begin
          mq.push_back('{instr: mem_word(mem_addr), pc_inc: mem_addr + 16'd2});
          m_pc = mem_addr + 16'd2;
        end
      end
      if (redirect) begin
        mq.delete();
        m_pc = redirect_pc;
        if (was_busy && !imem_done) m_stale = 1'b1;
      end
    end
  endtask

  task advance();
    if (imem_done) mem_busy = 1'b0;
    if (imem_rd === 1'b1 && !was_busy && !rst) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_due  = cyc + mem_lat;
      issues++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task tick();
    settle();
    advance();
  endtask

  task do_reset();
    int n;
    rst = 1'b1; redirect = 1'b0; halt = 1'b0; out_ready = 1'b0; err_inject = 1'b0;
    repeat (2) tick();
    n = 0;
    while (mem_busy && n < 20) begin
      tick();
      n++;
    end
    rst = 1'b0;
  endtask

  task test_reset();
    do_reset();
    settle();
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || err !== 1'b0 || perf_stall_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_state: got v%b c%0d e%b p%0d expected v0 c0 e0 p0",
                         out_valid, count, err, perf_stall_cnt);
    end
    checks++;
    if (imem_rd !== 1'b1 || imem_addr !== 16'h0000) begin
      errors++; $display("FAIL reset_first_rd: got rd %b addr %h expected rd 1 addr 0000", imem_rd, imem_addr);
    end
    advance();
  endtask

  task test_stream();
    logic [15:0] got_inc [4];
    logic [15:0] got_ins [4];
    int n;
    do_reset();
    out_ready = 1'b1; mem_lat = 1;
    settle(); advance();
    settle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL lat_valid_c1: got %b expected 0", out_valid);
    end
    advance();
    settle();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL lat_valid_c2: got %b expected 1", out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      got_inc[k] = 16'hFFFF; got_ins[k] = 16'hFFFF;
    end
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      if (i > 0) settle();
      if (out_valid === 1'b1 && out_ready) begin
        got_inc[n] = out_pc_inc;
        got_ins[n] = out_instr;
        n++;
      end
      advance();
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_inc[k] !== 16'(2 * (k + 1)) || got_ins[k] !== mem_word(16'(2 * k))) begin
        errors++; $display("FAIL stream_%0d: got %h/%h expected %h/%h", k, got_ins[k], got_inc[k],
                           mem_word(16'(2 * k)), 16'(2 * (k + 1)));
      end
    end
  endtask

  task test_backpressure();
    int base;
    do_reset();
    out_ready = 1'b0; mem_lat = 1;
    base = issues;
    repeat (30) tick();
    settle();
    checks++;
    if (issues - base != 4) begin
      errors++; $display("FAIL full_issues: got %0d expected 4", issues - base);
    end
    checks++;
    if (count !== 3'd4 || imem_rd !== 1'b0) begin
      errors++; $display("FAIL full_stop: got count %0d rd %b expected count 4 rd 0", count, imem_rd);
    end
    advance();
    out_ready = 1'b1;
    settle();
    checks++;
    if (imem_rd !== 1'b0) begin
      errors++; $display("FAIL pop_not_credited: got rd %b expected 0", imem_rd);
    end
    advance();
    out_ready = 1'b0;
    settle();
    checks++;
    if (imem_rd !== 1'b1 || imem_addr !== 16'h0008) begin
      errors++; $display("FAIL refill_rd: got rd %b addr %h expected rd 1 addr 0008", imem_rd, imem_addr);
    end
    advance();
    repeat (4) tick();
    settle();
    checks++;
    if (count !== 3'd4) begin
      errors++; $display("FAIL refill_count: got %0d expected 4", count);
    end
    advance();
  endtask

  task test_redirect();
    int n;
    do_reset();
    out_ready = 1'b0; mem_lat = 1;
    repeat (4) tick();
    mem_lat = 6;
    settle();
    checks++;
    if (count !== 3'd2 || imem_rd !== 1'b1 || imem_addr !== 16'h0004) begin
      errors++; $display("FAIL redir_pre: got count %0d rd %b addr %h expected 2 1 0004", count, imem_rd, imem_addr);
    end
    advance();
    repeat (2) tick();
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    settle();
    checks++;
    if (count !== 3'd0 || imem_rd !== 1'b0) begin
      errors++; $display("FAIL redir_flush: got count %0d rd %b expected 0 0", count, imem_rd);
    end
    advance();
    n = 0;
    while (mem_busy && n < 20) begin
      settle();
      checks++;
      if (imem_rd !== 1'b0) begin
        errors++; $display("FAIL drop_rd: got %b expected 0", imem_rd);
      end
      advance();
      n++;
    end
    settle();
    checks++;
    if (imem_rd !== 1'b1 || imem_addr !== 16'h0100 || count !== 3'd0) begin
      errors++; $display("FAIL redir_target: got rd %b addr %h count %0d expected 1 0100 0", imem_rd, imem_addr, count);
    end
    advance();
    mem_lat = 1;
    repeat (4) tick();
  endtask

  task test_wrap();
    do_reset();
    out_ready = 1'b0; mem_lat = 1;
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    settle();
    checks++;
    if (imem_rd !== 1'b1 || imem_addr !== 16'hFFFE) begin
      errors++; $display("FAIL wrap_rd: got rd %b addr %h expected 1 FFFE", imem_rd, imem_addr);
    end
    advance();
    tick();
    settle();
    checks++;
    if (out_valid !== 1'b1 || out_pc_inc !== 16'h0000 || out_instr !== mem_word(16'hFFFE)) begin
      errors++; $display("FAIL wrap_head: got v%b %h/%h expected v1 %h/0000", out_valid, out_instr, out_pc_inc,
                         mem_word(16'hFFFE));
    end
    checks++;
    if (imem_rd !== 1'b1 || imem_addr !== 16'h0000) begin
      errors++; $display("FAIL wrap_next: got rd %b addr %h expected 1 0000", imem_rd, imem_addr);
    end
    advance();
    repeat (2) tick();
  endtask

  task test_err();
    bit rd_seen;
    do_reset();
    out_ready = 1'b1; mem_lat = 1; err_inject = 1'b1;
    tick(); tick();
    err_inject = 1'b0;
    rd_seen = 1'b0;
    repeat (10) begin
      settle();
      if (imem_rd === 1'b1) rd_seen = 1'b1;
      advance();
    end
    settle();
    checks++;
    if (err !== 1'b1 || count !== 3'd0 || rd_seen) begin
      errors++; $display("FAIL err_sticky: got err %b count %0d rd_seen %b expected 1 0 0", err, count, rd_seen);
    end
    advance();
    do_reset();
    settle();
    checks++;
    if (err !== 1'b0 || imem_rd !== 1'b1) begin
      errors++; $display("FAIL err_cleared: got err %b rd %b expected 0 1", err, imem_rd);
    end
    advance();
    repeat (3) tick();
  endtask

  task test_late_done();
    int n;
    do_reset();
    out_ready = 1'b0; mem_lat = 5;
    repeat (3) tick();
    rst = 1'b1; halt = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (mem_busy && n < 20) begin
      tick();
      n++;
    end
    settle();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || imem_rd !== 1'b0) begin
      errors++; $display("FAIL late_done_ignored: got count %0d v%b rd %b expected 0 0 0", count, out_valid, imem_rd);
    end
    advance();
    halt = 1'b0;
    settle();
    checks++;
    if (imem_rd !== 1'b1 || imem_addr !== 16'h0000) begin
      errors++; $display("FAIL late_done_resume: got rd %b addr %h expected 1 0000", imem_rd, imem_addr);
    end
    advance();
    repeat (8) tick();
  endtask

  task test_perf();
    int base;
    int n;
    do_reset();
    out_ready = 1'b1; mem_lat = 6;
    base = issues;
    n = 0;
    while (!((issues - base >= 2) && !mem_busy) && n < 60) begin
      tick();
      if (issues - base >= 2) halt = 1'b1;
      n++;
    end
    settle();
    checks++;
    if (perf_stall_cnt !== (PERF ? 16'd10 : 16'd0)) begin
      errors++; $display("FAIL perf_cnt: got %0d expected %0d", perf_stall_cnt, PERF ? 10 : 0);
    end
    advance();
    halt = 1'b0; mem_lat = 1;
    repeat (3) tick();
  endtask

  task test_random();
    do_reset();
    repeat (1500) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      halt        = ($urandom_range(0, 15) == 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 16'($urandom);
      mem_lat     = $urandom_range(1, 4);
      tick();
    end
    redirect = 1'b0; halt = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_err();
    test_late_done();
    test_perf();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter WIDTH, default 16, address and instruction width in bits (multiple of 8, >=16).
REQ-002 Parameter DEPTH, default 4, instruction queue entries (power of 2, >=2).
REQ-003 Parameter RST_PC, default 16'h0000, PC loaded on reset.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 redirect  in  1  branch/jump taken; redirect_pc  in  WIDTH  target PC.
REQ-007 halt  in  1  level; blocks new memory requests while high.
REQ-008 imem_addr  out  WIDTH; imem_rd  out  1  read request to stalling instruction memory.
REQ-009 imem_data  in  WIDTH; imem_done  in  1  data valid pulse; imem_err  in  1  error qualified by imem_done.
REQ-010 out_valid  out  1; out_ready  in  1; out_instr  out  WIDTH; out_pc_inc  out  WIDTH  head entry to decode.
REQ-011 count  out  log2(DEPTH)+1  occupied entries; err  out  1  sticky fetch error.
REQ-012 perf_stall_cnt  out  16  memory wait-cycle counter (see Configuration).

Function
REQ-013 FSM states: IDLE, REQ, DROP, HALTED; exactly one memory request outstanding at most.
REQ-014 IDLE->REQ when ~halt & ~err & ~redirect & (count + 0) < DEPTH; pop in same cycle not credited.
REQ-015 In REQ: imem_rd=1, imem_addr=pc held stable until the cycle imem_done=1; imem_done ignored in issue cycle.
REQ-016 REQ & imem_done & ~redirect: push {imem_data, pc+WIDTH/8} at tail; pc <= pc+WIDTH/8 modulo 2^WIDTH; next state IDLE (HALTED if halt).
REQ-017 redirect (any state): queue flushed (count<=0), pc<=redirect_pc; if REQ and no imem_done same cycle -> DROP; else IDLE/HALTED per halt.
REQ-018 DROP: imem_rd=0; returning imem_done data and imem_err discarded; next state IDLE.
REQ-019 HALTED: no requests; ->IDLE when halt=0 and err=0; redirect still updates pc.
REQ-020 out_valid = (count!=0); out_instr/out_pc_inc show head combinationally (fall-through); pop on out_valid & out_ready.
REQ-021 Simultaneous push and pop: count unchanged, both pointers advance; pop of empty queue ignored.
REQ-022 imem_err & imem_done in REQ: err<=1, data not pushed, state->HALTED until reset.
REQ-023 Pointers wrap modulo DEPTH; count never exceeds DEPTH.
REQ-024 Earliest latency: rst low at cycle 0 -> imem_rd cycle 0; imem_done cycle 1 -> out_valid cycle 2.

Reset
REQ-025 rst: state IDLE, pc=RST_PC, count=0, pointers=0, err=0, perf_stall_cnt=0, imem_rd=0, out_valid=0.
REQ-026 rst mid-request: outstanding request abandoned, no push; late imem_done after reset in IDLE ignored.
REQ-027 rst has priority over redirect, halt and all handshakes.

Configuration
REQ-028 Macro FETCH_QUEUE_PERF_EN defined: perf_stall_cnt increments (saturating at 16'hFFFF) each cycle in REQ with imem_done=0.
REQ-029 FETCH_QUEUE_PERF_EN undefined: counter not built, perf_stall_cnt tied to 0.

Verification
REQ-030 Reset, done returned 1 cycle after each rd, out_ready=1 -> instrs at PCs 0,2,4,6 delivered in order, out_pc_inc 2,4,6,8.
REQ-031 out_ready=0, DEPTH=4 -> exactly 4 requests then imem_rd stays 0, count=4; one pop -> next request issued following cycle.
REQ-032 redirect to 16'h0100 while REQ pending 3 cycles -> DROP, stale data discarded, next imem_addr=16'h0100, count=0.
REQ-033 pc=16'hFFFE fetch -> out_pc_inc=16'h0000, next imem_addr=16'h0000.
REQ-034 imem_err with imem_done -> err=1, no push, no further imem_rd until rst; rst clears err.
REQ-035 With FETCH_QUEUE_PERF_EN, done delayed 5 cycles per request over 2 requests -> perf_stall_cnt=10; without macro -> 0.
